data_memory_responder: RTL

//   Memory-side responder for the lab CPU's data memory interface. Accepts one read or write request per

---
 rtl/datamem_pkg.sv | 15 +
 rtl/data_memory_array.sv | 36 +++
 rtl/data_memory_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/datamem_pkg.sv
// Shared types and widths for the data memory responder and its storage array.
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int CNT_WIDTH  = 4;

endpackage

// File: rtl/data_memory_array.sv
// Word-organised storage with byte-masked synchronous write and registered read on a shared index.
module data_memory_array
  import datamem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [WORD_BYTES-1:0][7:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0]      rdata_q;

  // Read-first on a shared index; the responder never reads and writes in the same request.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be_i[b]) begin
          mem[idx_i][b] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Valid/ready data memory responder: one request in, one response out after a fixed latency,
// held until the initiator accepts it.
module data_memory_responder
  import datamem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [WORD_BYTES-1:0] byteEnable,
  output logic                  respValid,
  input  logic                  respReady,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  respError
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   rd_ok_q, rd_ok_d;
  logic                   err_q, err_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   resp_err_q, resp_err_d;

  logic                   accept;
  logic                   addr_err;
  logic                   mem_we;
  logic                   mem_re;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  assign accept   = (state_q == IDLE) && reqValid;
  assign addr_err = (address[1:0] != 2'b00) ||
                    ({2'b00, address[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH_WORDS));
  assign mem_we   = accept && writeEnable && !addr_err;
  assign mem_re   = accept && !writeEnable && !addr_err;

  data_memory_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .be_i    (byteEnable),
    .idx_i   (address[IDX_W+1:2]),
    .wdata_i (dataIn),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_ok_d      = rd_ok_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    data_out_d   = data_out_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CNT_WIDTH'(1);
          rd_ok_d = !writeEnable && !addr_err;
          err_d   = addr_err;
        end
      end
      WAIT: begin
        // cnt_q equals the number of edges elapsed since acceptance.
        if (cnt_q == CNT_WIDTH'(READ_LATENCY)) begin
          state_d      = RESPOND;
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          data_out_d   = rd_ok_q ? mem_rdata : '0;
          resp_err_d   = err_q;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RESPOND: begin
        if (respReady) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          data_out_d   = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_ok_q      <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      data_out_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_ok_q      <= rd_ok_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      data_out_q   <= data_out_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign reqReady  = (state_q == IDLE);
  assign respValid = resp_valid_q;
  assign dataOut   = data_out_q;
  assign respError = resp_err_q;

endmodule
